// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one block memory port between the I-cache and D-cache.
// The winning request is latched on grant and held until mem_ready; ties alternate round-robin.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned DATA_W = 128
) (
  input  logic              clk,
  input  logic              proc_reset,
  // instruction cache side
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  // data cache side
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  // memory side
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_I    = 2'b01;
  localparam logic [1:0] GRANT_D    = 2'b10;

  state_e              state_q, state_d;
  logic                last_d_q, last_d_d;
  logic [1:0]          grant_q, grant_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                i_ready_c, d_ready_c;
  logic                i_req_c, d_req_c;
  logic                pick_i_c, pick_d_c;

  assign i_req_c  = i_mem_read;
  assign d_req_c  = d_mem_read | d_mem_write;
  // On a tie the side that did not win last time gets the port.
  assign pick_i_c = i_req_c & (~d_req_c | last_d_q);
  assign pick_d_c = d_req_c & (~i_req_c | ~last_d_q);

  // State and request registers.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q  <= IDLE;
      last_d_q <= 1'b1;
      grant_q  <= GRANT_NONE;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      grant_q  <= grant_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Next-state, request capture and response steering.
  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    grant_d   = grant_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_ready_c = 1'b0;
    d_ready_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_i_c) begin
          state_d = SERVE_I;
          grant_d = GRANT_I;
          rd_d    = 1'b1;
          wr_d    = 1'b0;
          addr_d  = i_mem_addr;
          wdata_d = '0;
        end else if (pick_d_c) begin
          state_d = SERVE_D;
          grant_d = GRANT_D;
          rd_d    = ~d_mem_write;
          wr_d    = d_mem_write;
          addr_d  = d_mem_addr;
          wdata_d = d_mem_wdata;
        end
      end
      SERVE_I: begin
        if (mem_ready) begin
          i_ready_c = 1'b1;
          last_d_d  = 1'b0;
          state_d   = IDLE;
          grant_d   = GRANT_NONE;
          rd_d      = 1'b0;
          wr_d      = 1'b0;
        end
      end
      SERVE_D: begin
        if (mem_ready) begin
          d_ready_c = 1'b1;
          last_d_d  = 1'b1;
          state_d   = IDLE;
          grant_d   = GRANT_NONE;
          rd_d      = 1'b0;
          wr_d      = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = GRANT_NONE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  assign mem_read    = rd_q;
  assign mem_write   = wr_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign grant       = grant_q;
  assign i_mem_ready = i_ready_c;
  assign d_mem_ready = d_ready_c;
  assign i_mem_rdata = mem_rdata;
  assign d_mem_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level owner model checked every cycle,
// plus literal expectations for the grant/address sequences of each scenario.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 28;
  localparam int unsigned DATA_W = 128;

  logic              clk = 1'b0;
  logic              proc_reset;
  logic              i_mem_read;
  logic [ADDR_W-1:0] i_mem_addr;
  logic [DATA_W-1:0] i_mem_rdata;
  logic              i_mem_ready;
  logic              d_mem_read;
  logic              d_mem_write;
  logic [ADDR_W-1:0] d_mem_addr;
  logic [DATA_W-1:0] d_mem_wdata;
  logic [DATA_W-1:0] d_mem_rdata;
  logic              d_mem_ready;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic [1:0]        grant;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .proc_reset(proc_reset),
    .i_mem_read(i_mem_read), .i_mem_addr(i_mem_addr),
    .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_addr(d_mem_addr),
    .d_mem_wdata(d_mem_wdata), .d_mem_rdata(d_mem_rdata), .d_mem_ready(d_mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .grant(grant)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Owner model: 0 = nobody, 1 = I-cache, 2 = D-cache.
  int                m_owner = 0;
  int                m_last  = 2;
  logic              m_wr    = 1'b0;
  logic [ADDR_W-1:0] m_addr  = '0;
  logic [DATA_W-1:0] m_wdata = '0;

  always @(posedge clk) begin
    if (proc_reset) begin
      m_owner <= 0;
      m_last  <= 2;
      m_wr    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else if (m_owner == 0) begin
      if (i_mem_read && (!(d_mem_read || d_mem_write) || m_last == 2)) begin
        m_owner <= 1;
        m_wr    <= 1'b0;
        m_addr  <= i_mem_addr;
        m_wdata <= '0;
      end else if (d_mem_read || d_mem_write) begin
        m_owner <= 2;
        m_wr    <= d_mem_write;
        m_addr  <= d_mem_addr;
        m_wdata <= d_mem_wdata;
      end
    end else if (mem_ready) begin
      m_last  <= m_owner;
      m_owner <= 0;
    end
  end

  bit   chk_en      = 1'b0;
  logic prev_strobe = 1'b0;
  int   i_rdy_cnt   = 0;
  int   d_rdy_cnt   = 0;
  int   strobe_cnt  = 0;

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("grant", 128'(grant), 128'(m_owner == 1 ? 2'b01 : (m_owner == 2 ? 2'b10 : 2'b00)));
      check("mem_read", 128'(mem_read), 128'(m_owner != 0 && !m_wr));
      check("mem_write", 128'(mem_write), 128'(m_owner != 0 && m_wr));
      check("mem_addr", 128'(mem_addr), 128'(m_addr));
      check("mem_wdata", mem_wdata, m_wdata);
      check("i_mem_ready", 128'(i_mem_ready), 128'(m_owner == 1 && mem_ready));
      check("d_mem_ready", 128'(d_mem_ready), 128'(m_owner == 2 && mem_ready));
      check("i_mem_rdata", i_mem_rdata, mem_rdata);
      check("d_mem_rdata", d_mem_rdata, mem_rdata);
      if (i_mem_ready) i_rdy_cnt++;
      if (d_mem_ready) d_rdy_cnt++;
      if ((mem_read || mem_write) && !prev_strobe) strobe_cnt++;
      prev_strobe = mem_read || mem_write;
    end
  end

  // Memory responder and completion log.
  int                lat      = 4;
  int                cnt      = 0;
  logic [DATA_W-1:0] rdata_pat = '0;
  logic [1:0]        log_grant[$];
  logic [ADDR_W-1:0] log_addr[$];
  logic              log_wr[$];

  task automatic tick();
    @(posedge clk);
    #1;
    if (mem_ready) begin
      mem_ready = 1'b0;
      cnt       = 0;
    end else if (mem_read || mem_write) begin
      cnt++;
      if (cnt >= lat) begin
        mem_ready = 1'b1;
        mem_rdata = rdata_pat;
        log_grant.push_back(grant);
        log_addr.push_back(mem_addr);
        log_wr.push_back(mem_write);
      end
    end else begin
      cnt = 0;
    end
  endtask

  task automatic wait_log(input int n, input int budget, input string name);
    int k = 0;
    while (log_grant.size() < n && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (log_grant.size() < n) begin
      errors++;
      $display("FAIL %s timeout completions=%0d required=%0d", name, log_grant.size(), n);
    end
  endtask

  int base;
  int scnt;
  int dcnt;
  int icnt;

  initial begin
    proc_reset  = 1'b1;
    i_mem_read  = 1'b0;
    i_mem_addr  = '0;
    d_mem_read  = 1'b0;
    d_mem_write = 1'b0;
    d_mem_addr  = '0;
    d_mem_wdata = '0;
    mem_rdata   = '0;
    mem_ready   = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    check("rst_grant", 128'(grant), 128'(2'b00));
    check("rst_strobes", 128'({mem_read, mem_write}), 128'(2'b00));
    check("rst_addr_wdata", 128'(mem_addr) | mem_wdata, 128'(0));
    proc_reset = 1'b0;

    // 1: single I read
    lat = 4;
    rdata_pat = {16{8'hA5}};
    i_mem_read = 1'b1;
    i_mem_addr = 28'h0000010;
    tick();
    check("t1_mem_read_c1", 128'(mem_read), 128'(1));
    check("t1_mem_addr_c1", 128'(mem_addr), 128'(28'h10));
    wait_log(1, 20, "t1");
    i_mem_read = 1'b0;
    #1;
    check("t1_i_ready", 128'(i_mem_ready), 128'(1));
    check("t1_i_rdata", i_mem_rdata, {16{8'hA5}});
    tick();
    tick();
    check("t1_grant_idle", 128'(grant), 128'(2'b00));
    check("t1_ready_counts", 128'({16'(i_rdy_cnt), 16'(d_rdy_cnt)}), 128'({16'd1, 16'd0}));

    // 2: D write-back
    rdata_pat = 128'h5;
    d_mem_write = 1'b1;
    d_mem_addr  = 28'h20;
    d_mem_wdata = 128'h1234;
    tick();
    check("t2_op", 128'({mem_read, mem_write}), 128'(2'b01));
    check("t2_wdata", mem_wdata, 128'h1234);
    wait_log(2, 20, "t2");
    d_mem_write = 1'b0;
    d_mem_wdata = '0;
    tick();
    tick();
    check("t2_d_ready_once", 128'(d_rdy_cnt), 128'(1));

    // 3: both held continuously, grants must alternate
    lat = 3;
    base = log_grant.size();
    i_mem_read = 1'b1;
    i_mem_addr = 28'h30;
    d_mem_read = 1'b1;
    d_mem_addr = 28'h40;
    wait_log(base + 4, 40, "t3");
    i_mem_read = 1'b0;
    d_mem_read = 1'b0;
    tick();
    tick();
    for (int j = 0; j < 4; j++) begin
      if (log_grant.size() > base + j) begin
        check($sformatf("t3_grant%0d", j), 128'(log_grant[base+j]), 128'(j % 2 == 0 ? 2'b01 : 2'b10));
        check($sformatf("t3_addr%0d", j), 128'(log_addr[base+j]), 128'(j % 2 == 0 ? 28'h30 : 28'h40));
      end
    end
    check("t3_ready_counts", 128'({16'(i_rdy_cnt), 16'(d_rdy_cnt)}), 128'({16'd3, 16'd3}));

    // 4: I drops on ready while D raises a new request in the same cycle
    lat = 2;
    base = log_grant.size();
    scnt = strobe_cnt;
    i_mem_read = 1'b1;
    i_mem_addr = 28'h60;
    wait_log(base + 1, 20, "t4_i");
    i_mem_read = 1'b0;
    d_mem_read = 1'b1;
    d_mem_addr = 28'h70;
    tick();
    check("t4_idle_gap", 128'(grant), 128'(2'b00));
    tick();
    check("t4_d_granted", 128'({grant, mem_read}), 128'({2'b10, 1'b1}));
    check("t4_d_addr", 128'(mem_addr), 128'(28'h70));
    wait_log(base + 2, 20, "t4_d");
    d_mem_read = 1'b0;
    tick();
    tick();
    check("t4_one_strobe_per_grant", 128'(strobe_cnt - scnt), 128'(2));

    // 5: spurious mem_ready in IDLE, then D read+write treated as write
    icnt = i_rdy_cnt;
    dcnt = d_rdy_cnt;
    mem_ready = 1'b1;
    tick();
    tick();
    check("t5_no_ready", 128'({16'(i_rdy_cnt - icnt), 16'(d_rdy_cnt - dcnt)}), 128'(0));
    check("t5_grant_idle", 128'(grant), 128'(2'b00));
    base = log_grant.size();
    d_mem_read  = 1'b1;
    d_mem_write = 1'b1;
    d_mem_addr  = 28'h50;
    d_mem_wdata = 128'hBEEF;
    tick();
    check("t5_write_only", 128'({mem_read, mem_write}), 128'(2'b01));
    wait_log(base + 1, 20, "t5");
    d_mem_read  = 1'b0;
    d_mem_write = 1'b0;
    tick();
    tick();
    if (log_wr.size() > base) check("t5_log_write", 128'(log_wr[base]), 128'(1));

    // 6: reset in the middle of a D service
    lat = 8;
    dcnt = d_rdy_cnt;
    d_mem_read = 1'b1;
    d_mem_addr = 28'h80;
    tick();
    tick();
    check("t6_serving_d", 128'(grant), 128'(2'b10));
    proc_reset = 1'b1;
    i_mem_read = 1'b1;
    i_mem_addr = 28'h90;
    tick();
    check("t6_reset_strobes", 128'({mem_read, mem_write}), 128'(2'b00));
    check("t6_reset_grant", 128'(grant), 128'(2'b00));
    proc_reset = 1'b0;
    lat = 3;
    base = log_grant.size();
    tick();
    check("t6_tie_to_i", 128'(grant), 128'(2'b01));
    check("t6_i_addr", 128'(mem_addr), 128'(28'h90));
    wait_log(base + 1, 20, "t6_i");
    i_mem_read = 1'b0;
    wait_log(base + 2, 20, "t6_d");
    d_mem_read = 1'b0;
    tick();
    tick();
    check("t6_d_ready_count", 128'(d_rdy_cnt - dcnt), 128'(1));
    if (log_grant.size() > base + 1)
      check("t6_order", 128'({log_grant[base], log_grant[base+1]}), 128'({2'b01, 2'b10}));

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter that shares one 128-bit block memory port between the instruction cache (read-only, 2-word or 1-word-block variants) and the data cache (read/write-back).
- Sits between the two caches and the memory model/controller.
- Latches the winning request, holds the memory interface stable until mem_ready, then routes the response back to the winner only.
- Ties are resolved round-robin.

Parameters:
ADDR_W  28  block address width (word address [29:2] / [30:3] sliced by caches)
DATA_W  128  block data width

Ports:
clk  in  1  clock
proc_reset  in  1  synchronous active-high reset
i_mem_read  in  1  I-cache block read request (level, held until i_mem_ready)
i_mem_addr  in  ADDR_W  I-cache block address
i_mem_rdata  out  DATA_W  read data to I-cache
i_mem_ready  out  1  one-cycle completion pulse to I-cache
d_mem_read  in  1  D-cache block read request
d_mem_write  in  1  D-cache block write-back request
d_mem_addr  in  ADDR_W  D-cache block address
d_mem_wdata  in  DATA_W  D-cache write-back data
d_mem_rdata  out  DATA_W  read data to D-cache
d_mem_ready  out  1  one-cycle completion pulse to D-cache
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_addr  out  ADDR_W  memory block address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
mem_ready  in  1  memory completion
grant  out  2  current owner: 2'b00 none, 2'b01 I, 2'b10 D

Interface decisions:
- One clock, clk.
- Reset proc_reset is synchronous and active-high.
- All state updates on posedge clk.

Behaviour:

Reset:
- state=IDLE, grant=00, last_grant=D (so the first tie goes to I).
- mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
- i_mem_ready=0, d_mem_ready=0.

State machine states: IDLE, SERVE_I, SERVE_D.

IDLE transitions:
- If i_req = i_mem_read and d_req = d_mem_read|d_mem_write are both low: stay.
- If exactly one request is high: go to that requester's SERVE state.
- If both are high: go to the SERVE state of the requester not equal to last_grant.

On the IDLE -> SERVE edge, register into request registers (these drive the memory outputs directly):
- address;
- op: for D, write wins if d_mem_write and d_mem_read are both high; I is always a read;
- wdata: d_mem_wdata for D, 0 for I.

SERVE_x:
- mem_read/mem_write/mem_addr/mem_wdata are held constant from the registers, independent of requester inputs.
- Requesters may drop requests combinationally when they see ready, so inputs are not sampled here.
- When mem_ready=1: x_mem_ready=1 combinationally in the same cycle, last_grant<=x, next state IDLE, and the registered strobes clear at that edge.
- Memory therefore sees exactly one request per grant.

Latency:
- A request first asserted in cycle n is seen by memory from cycle n+1.
- Back-to-back service needs one IDLE cycle between grants.
- Minimum turnaround is 2 cycles plus memory latency.

Response routing:
- mem_rdata is broadcast to both i_mem_rdata and d_mem_rdata.
- Only the granted side receives ready; the non-granted ready is always 0.

Other rules:
- mem_ready in IDLE is ignored: no ready is forwarded and no state change occurs.
- grant=01 in SERVE_I, 10 in SERVE_D, 00 in IDLE.
- Requester inputs are not sampled while in SERVE.
- A new request from the winner in the cycle after its ready competes normally in IDLE.
- Reset mid-operation: synchronous return to reset values at the next edge. The in-flight memory request is abandoned and no ready is forwarded.
- Starvation bound: with both requesters continuously active, grants strictly alternate I, D, I, D.
- No combinational path from requester inputs to mem_* outputs.
- Only the mem_ready -> x_mem_ready and mem_rdata -> x_mem_rdata paths are combinational.

Test Plan:
1. Reset then single I read: i_mem_read=1, i_mem_addr=28'h0000010; memory returns ready after 4 cycles with rdata=128'hA5..A5. Required: mem_read=1 and mem_addr=0x10 from cycle 1; i_mem_ready pulses 1 cycle with i_mem_rdata=A5..A5; d_mem_ready stays 0; grant returns to 00.
2. D write-back: d_mem_write=1, addr=0x20, wdata=128'h1234. Required: mem_write=1, mem_read=0, mem_wdata=0x1234 held for the full wait; d_mem_ready pulses once.
3. Simultaneous I read 0x30 and D read 0x40 held continuously with 3-cycle memory latency. Required: grant sequence I, D, I, D; memory addresses 0x30, 0x40, 0x30, 0x40; each ready is delivered to the matching side only.
4. Requester drops its request combinationally on ready, and D raises a new request in the same cycle as the I ready. Required: exactly one mem_read per grant; the D request is served after one IDLE cycle.
5. Spurious mem_ready=1 while IDLE. Required: no x_mem_ready and grant stays 00. D asserts read and write together at addr 0x50. Required: treated as a write only.
6. proc_reset asserted 2 cycles into SERVE_D. Required: next edge mem_read=mem_write=0, grant=00; no d_mem_ready; a subsequent tie goes to I first.
